// File: rtl/copy_adder_arbiter.sv
// Round-robin arbiter feeding a single approximate adder with a one-deep result register.
// The low Ke result bits are copied from one operand and only the upper field is added.
module copy_adder_arbiter #(
  parameter int BIT_WIDTH = 8,
  parameter int N_REQ     = 4,
  parameter int K_INIT    = 5,
  parameter int MODE_INIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*BIT_WIDTH-1:0]   req_a,
  input  logic [N_REQ*BIT_WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]             req_ready,
  input  logic                         cfg_we,
  input  logic [3:0]                   cfg_k,
  input  logic [1:0]                   cfg_mode,
  output logic                         res_valid,
  output logic [BIT_WIDTH:0]           res_data,
  output logic [$clog2(N_REQ)-1:0]     res_id,
  input  logic                         res_ready,
  output logic [15:0]                  ops_count
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [4:0] BW_CAP = (BIT_WIDTH > 16) ? 5'd16 : 5'(BIT_WIDTH);

  typedef enum logic [1:0] {
    MODE_EXACT  = 2'd0,
    MODE_COPY_A = 2'd1,
    MODE_COPY_B = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  logic [3:0]           k_reg;
  mode_t                mode_reg;
  logic [IW-1:0]        rr_ptr;

  logic                 acc_en;
  logic                 accept;
  logic                 grant_any;
  logic [IW-1:0]        grant_idx;
  logic [IW-1:0]        scan;
  logic [IW-1:0]        next_ptr;
  logic [BIT_WIDTH-1:0] a_sel;
  logic [BIT_WIDTH-1:0] b_sel;
  logic [4:0]           ke;
  logic [BIT_WIDTH:0]   a_ext;
  logic [BIT_WIDTH:0]   b_ext;
  logic [BIT_WIDTH:0]   low_mask;
  logic [BIT_WIDTH:0]   exact_sum;
  logic [BIT_WIDTH:0]   upper_sum;
  logic [BIT_WIDTH:0]   result;

  // Grant search starts at rr_ptr and wraps; only valids and the pointer are consulted.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int off = 0; off < N_REQ; off++) begin
      scan = IW'((int'(rr_ptr) + off) % N_REQ);
      if (!grant_any && req_valid[scan]) begin
        grant_any = 1'b1;
        grant_idx = scan;
      end
    end
  end

  assign acc_en    = !res_valid || res_ready;
  assign accept    = acc_en && grant_any && !rst;
  assign req_ready = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign next_ptr  = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IW'(i)) begin
        a_sel = req_a[i*BIT_WIDTH +: BIT_WIDTH];
        b_sel = req_b[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Ke clamps to the operand width, so K beyond it copies every low bit and the sum field is zero.
  always_comb begin
    ke        = ({1'b0, k_reg} > BW_CAP) ? BW_CAP : {1'b0, k_reg};
    a_ext     = {1'b0, a_sel};
    b_ext     = {1'b0, b_sel};
    low_mask  = ~({(BIT_WIDTH+1){1'b1}} << ke);
    exact_sum = a_ext + b_ext;
    upper_sum = ((a_ext >> ke) + (b_ext >> ke)) << ke;
    case (mode_reg)
      MODE_COPY_A: result = upper_sum | (a_ext & low_mask);
      MODE_COPY_B: result = upper_sum | (b_ext & low_mask);
      default:     result = exact_sum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
      ops_count <= '0;
      k_reg     <= 4'(K_INIT);
      mode_reg  <= mode_t'(2'(MODE_INIT));
    end else begin
      if (cfg_we) begin
        k_reg    <= cfg_k;
        mode_reg <= mode_t'(cfg_mode);
      end
      if (accept) begin
        res_valid <= 1'b1;
        res_data  <= result;
        res_id    <= grant_idx;
        rr_ptr    <= next_ptr;
        ops_count <= ops_count + 16'd1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
